// File: rtl/cg_result_writeback.sv
// cg_result_writeback
//   Write-back sequencer behind the CG ALU stage. It accepts per-word X/R/P
//   update vectors and drives the write ports of memories X, R and P.
//   Outputs are registered, and addresses auto-increment within each vector.
//   A full iteration is one X/R vector followed by one P vector. After that
//   the block pulses iter_done and bumps iteration_count. finish_all halts the
//   block until reset.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             leave idle and begin accepting X/R words
//   memory{X,R,P}_input  ALU update words (no_of_units*element_width bits)
//   we_xr, we_p       ALU strobes for the X/R word pair and for the P word
//   finish_all        ALU solve complete; enters the terminal halt state
//   mem{X,R,P}_wr_*   registered write data / address / enable
//   iter_done         one-cycle pulse per completed iteration
//   iteration_count   completed iterations (wraps at 2^32)
//   seq_error         sticky: strobe arrived in the wrong phase
//   halted            high once the halt state is entered
//
// Optional: define WB_ITER_LIMIT_EN to add parameter max_iterations and output
//   iter_limit_hit. The block halts itself after max_iterations iterations.
module cg_result_writeback #(
  parameter int number_of_clusters              = 40,
  parameter int number_of_equations_per_cluster = 19,
  parameter int element_width                   = 32,
  parameter int no_of_units                     = 8,
  parameter int memories_address_width          = 20
`ifdef WB_ITER_LIMIT_EN
  , parameter int max_iterations                = 1000
`endif
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [no_of_units*element_width-1:0]    memoryX_input,
  input  logic [no_of_units*element_width-1:0]    memoryR_input,
  input  logic [no_of_units*element_width-1:0]    memoryP_input,
  input  logic                                    we_xr,
  input  logic                                    we_p,
  input  logic                                    finish_all,
  output logic [no_of_units*element_width-1:0]    memX_wr_data,
  output logic [no_of_units*element_width-1:0]    memR_wr_data,
  output logic [no_of_units*element_width-1:0]    memP_wr_data,
  output logic [memories_address_width-1:0]       memX_wr_addr,
  output logic [memories_address_width-1:0]       memR_wr_addr,
  output logic [memories_address_width-1:0]       memP_wr_addr,
  output logic                                    memX_we,
  output logic                                    memR_we,
  output logic                                    memP_we,
  output logic                                    iter_done,
  output logic [31:0]                             iteration_count,
  output logic                                    seq_error,
  output logic                                    halted
`ifdef WB_ITER_LIMIT_EN
  , output logic                                  iter_limit_hit
`endif
);

  localparam int WPV = (number_of_clusters * number_of_equations_per_cluster
                        + no_of_units - 1) / no_of_units;
  localparam logic [31:0] WPV_LAST = 32'(WPV - 1);

  typedef enum logic [2:0] {S_IDLE, S_XR, S_P, S_ITER, S_HALT} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        xr_acc, p_acc, err_set, iter_pulse, halt_n;
  logic        lim_reached;

`ifdef WB_ITER_LIMIT_EN
  assign lim_reached = (iteration_count + 32'd1) == 32'(max_iterations);
`else
  assign lim_reached = 1'b0;
`endif

  // State register and word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state / counter logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (start) state_n = S_XR;
      S_XR: if (we_xr) begin
        if (cnt == WPV_LAST) begin
          cnt_n   = '0;
          state_n = S_P;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_P: if (we_p) begin
        if (cnt == WPV_LAST) begin
          cnt_n   = '0;
          state_n = S_ITER;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_ITER: state_n = lim_reached ? S_HALT : S_XR;
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
    // finish_all overrides the phase transition, but a strobe taken in the
    // same cycle has already advanced the counter and is still written.
    if (finish_all && state != S_HALT) state_n = S_HALT;
  end

  // Per-cycle decisions that feed the registered outputs
  always_comb begin
    xr_acc     = (state == S_XR) && we_xr;
    p_acc      = (state == S_P)  && we_p;
    err_set    = ((state == S_XR) && we_p) || ((state == S_P) && we_xr);
    iter_pulse = (state == S_ITER);
    halt_n     = (state_n == S_HALT);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      memX_wr_data    <= '0;
      memR_wr_data    <= '0;
      memP_wr_data    <= '0;
      memX_wr_addr    <= '0;
      memR_wr_addr    <= '0;
      memP_wr_addr    <= '0;
      memX_we         <= 1'b0;
      memR_we         <= 1'b0;
      memP_we         <= 1'b0;
      iter_done       <= 1'b0;
      iteration_count <= '0;
      seq_error       <= 1'b0;
      halted          <= 1'b0;
    end else begin
      memX_we   <= xr_acc;
      memR_we   <= xr_acc;
      memP_we   <= p_acc;
      iter_done <= iter_pulse;
      if (xr_acc) begin
        memX_wr_data <= memoryX_input;
        memR_wr_data <= memoryR_input;
        memX_wr_addr <= memories_address_width'(cnt);
        memR_wr_addr <= memories_address_width'(cnt);
      end
      if (p_acc) begin
        memP_wr_data <= memoryP_input;
        memP_wr_addr <= memories_address_width'(cnt);
      end
      if (iter_pulse) iteration_count <= iteration_count + 32'd1;
      if (err_set)    seq_error       <= 1'b1;
      if (halt_n)     halted          <= 1'b1;
    end
  end

`ifdef WB_ITER_LIMIT_EN
  always_ff @(posedge clk) begin
    if (reset)                           iter_limit_hit <= 1'b0;
    else if (iter_pulse && lim_reached)  iter_limit_hit <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cg_result_writeback.sv
module tb_cg_result_writeback;
  localparam int EW  = 32;
  localparam int U   = 8;
  localparam int AW  = 20;
  localparam int DW  = U * EW;
  localparam int WPV = 95;   // ceil(40*19/8)

  logic          clk = 0, reset = 1, start = 0;
  logic [DW-1:0] memoryX_input = '0, memoryR_input = '0, memoryP_input = '0;
  logic          we_xr = 0, we_p = 0, finish_all = 0;
  logic [DW-1:0] memX_wr_data, memR_wr_data, memP_wr_data;
  logic [AW-1:0] memX_wr_addr, memR_wr_addr, memP_wr_addr;
  logic          memX_we, memR_we, memP_we, iter_done, seq_error, halted;
  logic [31:0]   iteration_count;
`ifdef WB_ITER_LIMIT_EN
  logic          iter_limit_hit;
`endif

  int checks = 0, failures = 0;
  int exp_iters = 0;
  logic [DW-1:0] x_w, r_w, p_w;

  cg_result_writeback #(
    .number_of_clusters(40), .number_of_equations_per_cluster(19),
    .element_width(EW), .no_of_units(U), .memories_address_width(AW)
`ifdef WB_ITER_LIMIT_EN
    , .max_iterations(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .memoryX_input(memoryX_input), .memoryR_input(memoryR_input),
    .memoryP_input(memoryP_input), .we_xr(we_xr), .we_p(we_p),
    .finish_all(finish_all),
    .memX_wr_data(memX_wr_data), .memR_wr_data(memR_wr_data),
    .memP_wr_data(memP_wr_data), .memX_wr_addr(memX_wr_addr),
    .memR_wr_addr(memR_wr_addr), .memP_wr_addr(memP_wr_addr),
    .memX_we(memX_we), .memR_we(memR_we), .memP_we(memP_we),
    .iter_done(iter_done), .iteration_count(iteration_count),
    .seq_error(seq_error), .halted(halted)
`ifdef WB_ITER_LIMIT_EN
    , .iter_limit_hit(iter_limit_hit)
`endif
  );

  always #5 clk = ~clk;

  // One clock with the given strobes and fresh random words; returns 1ns after
  // the edge so outputs reflect what was accepted on that edge.
  task automatic drive(input logic xr, input logic p, input logic fin, input logic st);
    for (int i = 0; i < U; i++) begin
      x_w[i*EW +: EW] = $urandom;
      r_w[i*EW +: EW] = $urandom;
      p_w[i*EW +: EW] = $urandom;
    end
    memoryX_input = x_w; memoryR_input = r_w; memoryP_input = p_w;
    we_xr = xr; we_p = p; finish_all = fin; start = st;
    @(posedge clk); #1;
    we_xr = 0; we_p = 0; finish_all = 0; start = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    drive(0, 0, 0, 0);
    reset = 0;
    exp_iters = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 0);
    reset = 0;
    checks++;
    if ({memX_we, memR_we, memP_we, iter_done, seq_error, halted} !== 6'b0 ||
        iteration_count !== 32'd0 || memX_wr_addr !== '0 || memP_wr_addr !== '0 ||
        memX_wr_data !== '0 || memR_wr_data !== '0 || memP_wr_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs we=%b%b%b iter_done=%b err=%b halted=%b cnt=%0d, all required 0",
               memX_we, memR_we, memP_we, iter_done, seq_error, halted, iteration_count);
    end
`ifdef WB_ITER_LIMIT_EN
    checks++;
    if (iter_limit_hit !== 1'b0) begin
      failures++; $display("FAIL reset_limit iter_limit_hit=%b required 0", iter_limit_hit);
    end
`endif
  endtask

  // One full X/R vector followed by one P vector, optionally with idle gaps.
  task automatic test_iteration(input bit gaps);
    drive(0, 0, 0, 1);
    checks++;
    if (memX_we !== 1'b0 || memP_we !== 1'b0) begin
      failures++; $display("FAIL start_no_write xwe=%b pwe=%b required 0", memX_we, memP_we);
    end
    for (int k = 0; k < WPV; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive(0, 0, 0, 0);
        checks++;
        if (memX_we !== 1'b0 || memR_we !== 1'b0) begin
          failures++; $display("FAIL xr_gap k=%0d xwe=%b rwe=%b required 0", k, memX_we, memR_we);
        end
      end
      drive(1, 0, 0, 0);
      checks++;
      if (memX_we !== 1'b1 || memR_we !== 1'b1 || memP_we !== 1'b0 ||
          memX_wr_addr !== AW'(k) || memR_wr_addr !== AW'(k) ||
          memX_wr_data !== x_w || memR_wr_data !== r_w || iter_done !== 1'b0) begin
        failures++;
        $display("FAIL xr_write k=%0d we=%b%b%b addr=%0d/%0d data_ok=%b iter_done=%b required we=110 addr=%0d",
                 k, memX_we, memR_we, memP_we, memX_wr_addr, memR_wr_addr,
                 (memX_wr_data === x_w) && (memR_wr_data === r_w), iter_done, k);
      end
    end
    for (int k = 0; k < WPV; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive(0, 0, 0, 0);
        checks++;
        if (memP_we !== 1'b0) begin
          failures++; $display("FAIL p_gap k=%0d pwe=%b required 0", k, memP_we);
        end
      end
      drive(0, 1, 0, 0);
      checks++;
      if (memP_we !== 1'b1 || memX_we !== 1'b0 || memP_wr_addr !== AW'(k) ||
          memP_wr_data !== p_w || iter_done !== 1'b0) begin
        failures++;
        $display("FAIL p_write k=%0d pwe=%b xwe=%b addr=%0d data_ok=%b iter_done=%b required pwe=1 addr=%0d",
                 k, memP_we, memX_we, memP_wr_addr, memP_wr_data === p_w, iter_done, k);
      end
    end
    // Boundary cycle: strobes here are ignored silently, iteration is counted.
    drive(1'($urandom), 1'($urandom), 0, 0);
    exp_iters++;
    checks++;
    if (iter_done !== 1'b1 || iteration_count !== 32'(exp_iters) ||
        memX_we !== 1'b0 || memP_we !== 1'b0 || seq_error !== 1'b0) begin
      failures++;
      $display("FAIL iter_done pulse=%b count=%0d xwe=%b pwe=%b err=%b required 1 %0d 0 0 0",
               iter_done, iteration_count, memX_we, memP_we, seq_error, exp_iters);
    end
  endtask

`ifdef WB_ITER_LIMIT_EN
  task automatic test_iter_limit();
    int writes = 0;
    checks++;
    if (iter_limit_hit !== 1'b1 || halted !== 1'b1 || iteration_count !== 32'd2) begin
      failures++;
      $display("FAIL iter_limit hit=%b halted=%b count=%0d required 1 1 2",
               iter_limit_hit, halted, iteration_count);
    end
    for (int k = 0; k < 2 * WPV; k++) begin
      drive(k < WPV, k >= WPV, 0, 1);
      writes += int'(memX_we) + int'(memR_we) + int'(memP_we);
    end
    checks++;
    if (writes != 0 || iter_done !== 1'b0 || iteration_count !== 32'd2) begin
      failures++;
      $display("FAIL iter_limit_writes writes=%0d iter_done=%b count=%0d required 0 0 2",
               writes, iter_done, iteration_count);
    end
  endtask
`else
  task automatic test_next_vector();
    drive(1, 0, 0, 0);
    checks++;
    if (memX_we !== 1'b1 || memX_wr_addr !== '0 || iter_done !== 1'b0 ||
        iteration_count !== 32'(exp_iters)) begin
      failures++;
      $display("FAIL next_vector xwe=%b addr=%0d iter_done=%b count=%0d required 1 0 0 %0d",
               memX_we, memX_wr_addr, iter_done, iteration_count, exp_iters);
    end
  endtask
`endif

  task automatic test_phase_error();
    do_reset();
    drive(1, 1, 0, 0);   // idle: ignored, no error
    checks++;
    if (memX_we !== 1'b0 || memP_we !== 1'b0 || seq_error !== 1'b0) begin
      failures++;
      $display("FAIL idle_strobe xwe=%b pwe=%b err=%b required 0 0 0", memX_we, memP_we, seq_error);
    end
    drive(0, 0, 0, 1);
    for (int k = 0; k < 10; k++) drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    checks++;
    if (memP_we !== 1'b0 || memX_we !== 1'b0 || seq_error !== 1'b1) begin
      failures++;
      $display("FAIL p_in_xr pwe=%b xwe=%b err=%b required 0 0 1", memP_we, memX_we, seq_error);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (memX_we !== 1'b1 || memX_wr_addr !== AW'(10) || seq_error !== 1'b1) begin
      failures++;
      $display("FAIL after_error xwe=%b addr=%0d err=%b required 1 10 1", memX_we, memX_wr_addr, seq_error);
    end
    drive(1, 1, 0, 0);
    checks++;
    if (memX_we !== 1'b1 || memX_wr_addr !== AW'(11) || memX_wr_data !== x_w || memP_we !== 1'b0) begin
      failures++;
      $display("FAIL both_strobes xwe=%b addr=%0d pwe=%b required 1 11 0", memX_we, memX_wr_addr, memP_we);
    end
    do_reset();
    checks++;
    if (seq_error !== 1'b0) begin
      failures++; $display("FAIL err_clear err=%b required 0", seq_error);
    end
  endtask

  task automatic test_finish();
    int writes = 0;
    do_reset();
    drive(0, 0, 0, 1);
    for (int k = 0; k < 40; k++) drive(1, 0, 0, 0);
    checks++;
    if (halted !== 1'b0) begin
      failures++; $display("FAIL pre_halt halted=%b required 0", halted);
    end
    drive(1, 0, 1, 0);
    checks++;
    if (memX_we !== 1'b1 || memX_wr_addr !== AW'(40) || memX_wr_data !== x_w || halted !== 1'b1) begin
      failures++;
      $display("FAIL finish_write xwe=%b addr=%0d halted=%b required 1 40 1", memX_we, memX_wr_addr, halted);
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      writes += int'(memX_we) + int'(memR_we) + int'(memP_we);
    end
    checks++;
    if (writes != 0 || halted !== 1'b1 || seq_error !== 1'b0) begin
      failures++;
      $display("FAIL halted_ignore writes=%0d halted=%b err=%b required 0 1 0", writes, halted, seq_error);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    checks++;
    if (memX_we !== 1'b1 || memX_wr_addr !== '0) begin
      failures++; $display("FAIL mid_pre xwe=%b addr=%0d required 1 0", memX_we, memX_wr_addr);
    end
    reset = 1;
    drive(1, 0, 0, 0);
    reset = 0;
    checks++;
    if (memX_we !== 1'b0 || memR_we !== 1'b0 || memX_wr_addr !== '0 ||
        iteration_count !== 32'd0 || halted !== 1'b0 || seq_error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset xwe=%b rwe=%b addr=%0d count=%0d halted=%b required all 0",
               memX_we, memR_we, memX_wr_addr, iteration_count, halted);
    end
    drive(1, 0, 0, 0);   // back in idle: no write without start
    checks++;
    if (memX_we !== 1'b0) begin
      failures++; $display("FAIL mid_idle xwe=%b required 0", memX_we);
    end
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    checks++;
    if (memX_we !== 1'b1 || memX_wr_addr !== '0) begin
      failures++; $display("FAIL mid_restart xwe=%b addr=%0d required 1 0", memX_we, memX_wr_addr);
    end
  endtask

  initial begin
    test_reset();
    test_iteration(0);
    test_iteration(1);
`ifdef WB_ITER_LIMIT_EN
    test_iter_limit();
`else
    test_next_vector();
`endif
    test_phase_error();
    test_finish();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
